// File: rtl/rate_pulse_generator.sv
// Rate pulse generator: divides Clock by one of four selectable periods and emits
// a one-cycle Pulse per period while running, plus a wrapping count of pulses issued.
module rate_pulse_generator #(
   parameter int unsigned CNT_W   = 28,
   parameter int unsigned PERIOD0 = 1,
   parameter int unsigned PERIOD1 = 25_000_000,
   parameter int unsigned PERIOD2 = 50_000_000,
   parameter int unsigned PERIOD3 = 100_000_000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [1:0] Speed,
   input  logic       Start,
   input  logic       Stop,
   output logic       Pulse,
   output logic       Running,
   output logic [7:0] PulseCount
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] count, count_d;
   logic             pulse_d;
   logic [7:0]       pcount_d;

   // The period is captured into the down-counter as P-1 at every load/reload,
   // so Speed changes mid-period only take effect at the next reload.
   function automatic logic [CNT_W-1:0] reload_value(input logic [1:0] sel);
      int unsigned p;
      case (sel)
         2'b00:   p = PERIOD0;
         2'b01:   p = PERIOD1;
         2'b10:   p = PERIOD2;
         default: p = PERIOD3;
      endcase
      if (p == 0) p = 1;
      return CNT_W'(p - 1);
   endfunction

   // NOTE: every output of this block gets a default first, so no path can leave
   // a signal unassigned and infer a latch.
   always_comb begin
      state_d  = state;
      count_d  = count;
      pulse_d  = 1'b0;
      pcount_d = PulseCount;
      case (state)
         IDLE: begin
            count_d = '0;
            if (Start && !Stop) begin
               state_d = RUN;
               count_d = reload_value(Speed);
            end
         end
         RUN: begin
            if (Stop) begin
               state_d = IDLE;
               count_d = '0;
            end else if (Start) begin
               count_d = reload_value(Speed);
            end else if (count == '0) begin
               pulse_d  = 1'b1;
               pcount_d = PulseCount + 8'd1;
               count_d  = reload_value(Speed);
            end else begin
               count_d = count - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         count      <= '0;
         Pulse      <= 1'b0;
         PulseCount <= 8'd0;
      end else begin
         state      <= state_d;
         count      <= count_d;
         Pulse      <= pulse_d;
         PulseCount <= pcount_d;
      end
   end

   assign Running = (state == RUN);

endmodule
